// File: rtl/cfg_regs_pkg.sv
// Shared register map, CTRL/STATUS bit positions and default identity for cfg_regs.
package cfg_regs_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_ADDR   = 2;
  localparam int REG_LEN    = 3;
  localparam int REG_CYCLES = 4;
  localparam int REG_ID     = 5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  localparam logic [31:0] CORE_ID_DEFAULT = 32'h0C0F_0001;

endpackage

// File: rtl/cfg_regs.sv
// Control/status register file for a single engine: writes land on the strobe edge,
// reads return one cycle after cfg_rd_en; no backpressure, strobes are always accepted.
module cfg_regs
  import cfg_regs_pkg::*;
#(
  parameter int                   AXI_WIDTH  = 32,
  parameter int                   CFG_AWIDTH = 5,
  parameter logic [AXI_WIDTH-1:0] CORE_ID    = AXI_WIDTH'(CORE_ID_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_WIDTH-1:0]  cfg_wr_data,
  input  logic [CFG_AWIDTH-1:0] cfg_wr_addr,
  input  logic                  cfg_wr_en,
  input  logic [CFG_AWIDTH-1:0] cfg_rd_addr,
  input  logic                  cfg_rd_en,
  output logic [AXI_WIDTH-1:0]  cfg_rd_data,
  output logic                  ctrl_enable,
  output logic                  ctrl_start,
  output logic [AXI_WIDTH-1:0]  ctrl_addr,
  output logic [AXI_WIDTH-1:0]  ctrl_len,
  input  logic                  stat_busy,
  input  logic                  stat_done,
  output logic                  irq
);

  logic                 enable_q, enable_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic                 irq_q, irq_d;
  logic [AXI_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_WIDTH-1:0] len_q, len_d;
  logic [AXI_WIDTH-1:0] cycles_q, cycles_d;
  logic [AXI_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [AXI_WIDTH-1:0] rd_val;
  logic                 wr_ctrl, wr_status, err_set;

  assign wr_ctrl   = cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(REG_CTRL));
  assign wr_status = cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(REG_STATUS));

  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    addr_d   = addr_q;
    len_d    = len_q;
    start_d  = 1'b0;
    err_set  = 1'b0;
    if (wr_ctrl) begin
      enable_d = cfg_wr_data[CTRL_EN_BIT];
      irq_en_d = cfg_wr_data[CTRL_IRQ_EN_BIT];
      // A start request is only honoured against the newly written enable and an idle engine.
      if (cfg_wr_data[CTRL_START_BIT]) begin
        if (cfg_wr_data[CTRL_EN_BIT] && !stat_busy) start_d = 1'b1;
        else                                         err_set = 1'b1;
      end
    end
    if (cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(REG_ADDR))) addr_d = cfg_wr_data;
    if (cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(REG_LEN)))  len_d  = cfg_wr_data;

    // Set terms are OR-ed after the clear so a coincident event wins over W1C.
    done_d = (done_q & ~(wr_status & cfg_wr_data[STAT_DONE_BIT])) | stat_done;
    err_d  = (err_q  & ~(wr_status & cfg_wr_data[STAT_ERR_BIT]))  | err_set;

    cycles_d = cycles_q;
    if (start_d)                                 cycles_d = '0;
    else if (stat_busy && (cycles_q != '1))      cycles_d = cycles_q + 1'b1;

    irq_d = irq_en_q & (done_q | err_q);
  end

  // Read mux sees only current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (cfg_rd_addr)
      CFG_AWIDTH'(REG_CTRL): begin
        rd_val[CTRL_EN_BIT]     = enable_q;
        rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      CFG_AWIDTH'(REG_STATUS): begin
        rd_val[STAT_BUSY_BIT] = stat_busy;
        rd_val[STAT_DONE_BIT] = done_q;
        rd_val[STAT_ERR_BIT]  = err_q;
      end
      CFG_AWIDTH'(REG_ADDR):   rd_val = addr_q;
      CFG_AWIDTH'(REG_LEN):    rd_val = len_q;
      CFG_AWIDTH'(REG_CYCLES): rd_val = cycles_q;
      CFG_AWIDTH'(REG_ID):     rd_val = CORE_ID;
      default:                 rd_val = '0;
    endcase
    rd_data_d = cfg_rd_en ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cycles_q  <= '0;
      rd_data_q <= '0;
    end else begin
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cycles_q  <= cycles_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign cfg_rd_data = rd_data_q;
  assign ctrl_enable = enable_q;
  assign ctrl_start  = start_q;
  assign ctrl_addr   = addr_q;
  assign ctrl_len    = len_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_cfg_regs.sv
// Directed bench for cfg_regs; a narrow 8-bit instance exercises CYCLES saturation in few cycles.
module tb_cfg_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_wr_data = '0;
  logic [4:0]  cfg_wr_addr = '0;
  logic        cfg_wr_en   = 1'b0;
  logic [4:0]  cfg_rd_addr = '0;
  logic        cfg_rd_en   = 1'b0;
  logic [31:0] cfg_rd_data;
  logic        ctrl_enable, ctrl_start, irq;
  logic [31:0] ctrl_addr, ctrl_len;
  logic        stat_busy = 1'b0;
  logic        stat_done = 1'b0;

  logic [7:0]  rd_addr8_unused;
  logic [4:0]  cfg_rd_addr8 = '0;
  logic        cfg_rd_en8   = 1'b0;
  logic        stat_busy8   = 1'b0;
  logic [7:0]  cfg_rd_data8, ctrl_addr8, ctrl_len8;
  logic        ctrl_enable8, ctrl_start8, irq8;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rdv;

  always #5 clk = ~clk;

  cfg_regs dut (
    .clk(clk), .rst(rst),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_en(cfg_wr_en),
    .cfg_rd_addr(cfg_rd_addr), .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data),
    .ctrl_enable(ctrl_enable), .ctrl_start(ctrl_start),
    .ctrl_addr(ctrl_addr), .ctrl_len(ctrl_len),
    .stat_busy(stat_busy), .stat_done(stat_done), .irq(irq)
  );

  cfg_regs #(.AXI_WIDTH(8), .CFG_AWIDTH(5), .CORE_ID(8'hA5)) dut8 (
    .clk(clk), .rst(rst),
    .cfg_wr_data(8'h00), .cfg_wr_addr(5'd0), .cfg_wr_en(1'b0),
    .cfg_rd_addr(cfg_rd_addr8), .cfg_rd_en(cfg_rd_en8), .cfg_rd_data(cfg_rd_data8),
    .ctrl_enable(ctrl_enable8), .ctrl_start(ctrl_start8),
    .ctrl_addr(ctrl_addr8), .ctrl_len(ctrl_len8),
    .stat_busy(stat_busy8), .stat_done(1'b0), .irq(irq8)
  );

  assign rd_addr8_unused = ctrl_addr8 | ctrl_len8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick(1);
    cfg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cfg_rd_en = 1'b1; cfg_rd_addr = a;
    tick(1);
    cfg_rd_en = 1'b0;
    d = cfg_rd_data;
  endtask

  initial begin
    #2;
    chk("rst_rd_data", cfg_rd_data, 32'h0);
    chk("rst_enable",  {31'h0, ctrl_enable}, 32'h0);
    chk("rst_start",   {31'h0, ctrl_start}, 32'h0);
    chk("rst_addr",    ctrl_addr, 32'h0);
    chk("rst_len",     ctrl_len, 32'h0);
    chk("rst_irq",     {31'h0, irq}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // ADDR/LEN write and readback
    wr(5'd2, 32'h1000_0000);
    wr(5'd3, 32'h0000_0040);
    chk("ctrl_addr", ctrl_addr, 32'h1000_0000);
    chk("ctrl_len",  ctrl_len, 32'h0000_0040);
    rd(5'd2, rdv); chk("rd_addr", rdv, 32'h1000_0000);
    rd(5'd3, rdv); chk("rd_len", rdv, 32'h0000_0040);
    tick(2);       chk("rd_hold", cfg_rd_data, 32'h0000_0040);
    rd(5'd5, rdv); chk("rd_id", rdv, 32'h0C0F_0001);
    wr(5'd6, 32'hFFFF_FFFF);
    rd(5'd6, rdv); chk("rd_unmapped", rdv, 32'h0);

    // Successful start
    wr(5'd0, 32'h3);
    chk("start_pulse", {31'h0, ctrl_start}, 32'h1);
    tick(1);
    chk("start_one_cycle", {31'h0, ctrl_start}, 32'h0);
    rd(5'd0, rdv); chk("rd_ctrl_after_start", rdv, 32'h1);
    rd(5'd4, rdv); chk("rd_cycles_after_start", rdv, 32'h0);
    rd(5'd1, rdv); chk("rd_status_clean", rdv, 32'h0);

    // Start with enable=0 -> err
    wr(5'd0, 32'h2);
    chk("no_start_disabled", {31'h0, ctrl_start}, 32'h0);
    chk("enable_cleared", {31'h0, ctrl_enable}, 32'h0);
    rd(5'd1, rdv); chk("rd_status_err", rdv, 32'h4);
    wr(5'd1, 32'h4);
    rd(5'd1, rdv); chk("rd_status_err_w1c", rdv, 32'h0);

    // Start while busy -> err, irq masked
    stat_busy = 1'b1;
    wr(5'd0, 32'h3);
    chk("no_start_busy", {31'h0, ctrl_start}, 32'h0);
    stat_busy = 1'b0;
    rd(5'd1, rdv); chk("rd_status_err_busy", rdv, 32'h4);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(5'd1, 32'h4);

    // Start clears CYCLES, then count 10 busy cycles and complete
    wr(5'd0, 32'h3);
    chk("restart_pulse", {31'h0, ctrl_start}, 32'h1);
    wr(5'd0, 32'h5);
    stat_busy = 1'b1;
    tick(10);
    stat_busy = 1'b0;
    stat_done = 1'b1;
    tick(1);
    stat_done = 1'b0;
    rd(5'd4, rdv); chk("rd_cycles_10", rdv, 32'd10);
    chk("irq_done", {31'h0, irq}, 32'h1);
    rd(5'd1, rdv); chk("rd_status_done", rdv, 32'h2);

    // W1C of done concurrent with a new stat_done: set wins
    cfg_wr_en = 1'b1; cfg_wr_addr = 5'd1; cfg_wr_data = 32'h2; stat_done = 1'b1;
    tick(1);
    cfg_wr_en = 1'b0; stat_done = 1'b0;
    rd(5'd1, rdv); chk("done_set_wins", rdv, 32'h2);
    wr(5'd1, 32'h2);
    rd(5'd1, rdv); chk("done_w1c", rdv, 32'h0);
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Read and write of ADDR in the same cycle returns the old value
    cfg_wr_en = 1'b1; cfg_wr_addr = 5'd2; cfg_wr_data = 32'h0000_2222;
    cfg_rd_en = 1'b1; cfg_rd_addr = 5'd2;
    tick(1);
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    chk("rd_during_wr", cfg_rd_data, 32'h1000_0000);
    rd(5'd2, rdv); chk("rd_after_wr", rdv, 32'h0000_2222);

    // CYCLES saturation on the 8-bit instance
    stat_busy8 = 1'b1;
    tick(200);
    cfg_rd_en8 = 1'b1; cfg_rd_addr8 = 5'd4;
    tick(1);
    cfg_rd_en8 = 1'b0;
    chk("cycles8_200", {24'h0, cfg_rd_data8}, 32'd200);
    tick(100);
    cfg_rd_en8 = 1'b1;
    tick(1);
    cfg_rd_en8 = 1'b0;
    chk("cycles8_sat", {24'h0, cfg_rd_data8}, 32'hFF);
    tick(5);
    cfg_rd_en8 = 1'b1;
    tick(1);
    cfg_rd_en8 = 1'b0;
    stat_busy8 = 1'b0;
    chk("cycles8_sat_hold", {24'h0, cfg_rd_data8}, 32'hFF);
    chk("id8", {31'h0, ctrl_start8 | ctrl_enable8 | irq8}, 32'h0);

    // Asynchronous reset while busy
    wr(5'd2, 32'h55);
    stat_busy = 1'b1;
    wr(5'd0, 32'h7);
    tick(2);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    chk("pre_rst_enable", {31'h0, ctrl_enable}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_enable",  {31'h0, ctrl_enable}, 32'h0);
    chk("arst_irq",     {31'h0, irq}, 32'h0);
    chk("arst_addr",    ctrl_addr, 32'h0);
    chk("arst_rd_data", cfg_rd_data, 32'h0);
    chk("arst_start",   {31'h0, ctrl_start}, 32'h0);
    tick(2);
    rst = 1'b0;
    stat_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("no_start_after_rst", {31'h0, ctrl_start}, 32'h0);
    end
    rd(5'd2, rdv); chk("rd_addr_after_rst", rdv, 32'h0);
    rd(5'd1, rdv); chk("rd_status_after_rst", rdv, 32'h0);
    rd(5'd4, rdv); chk("rd_cycles_after_rst", rdv, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
